fir_xifu_simd_ex: RTL and testbench

//  Parametrised execute stage of the FIR XIFU coprocessor. Sits between ID and WB.
//  Ops:
//   - XFIRDOTP: N-lane signed dot product with accumulate, wrapping.
//   - XFIRDOTPS: shift/round/saturate variant.
//   - XFIRLW/XFIRSW: post-increment load/store, multi-cycle memory handshake.

---
 rtl/fir_xifu_simd_ex.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fir_xifu_simd_ex.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_xifu_simd_ex.sv
// Execute stage of the FIR XIFU coprocessor: SIMD dot product (wrapping and
// saturating), post-increment load/store with a memory handshake, commit-kill.
module fir_xifu_simd_ex #(
  parameter int unsigned NLANES = 2,
  parameter int unsigned LANE_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       id_valid_i,
  output logic                       id_ready_o,
  input  logic [2:0]                 id_instr_i,
  input  logic [ID_W-1:0]            id_id_i,
  input  logic [4:0]                 id_rd_i,
  input  logic [4:0]                 id_rs1_i,
  input  logic [31:0]                id_base_i,
  input  logic [11:0]                id_offset_i,
  input  logic [NLANES*LANE_W-1:0]   op_a_i,
  input  logic [NLANES*LANE_W-1:0]   op_b_i,
  input  logic [ACC_W-1:0]           op_c_i,
  input  logic [$clog2(ACC_W)-1:0]   shift_i,
  input  logic [31:0]                sdata_i,
  input  logic                       kill_i,
  input  logic [ID_W-1:0]            kill_id_i,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic [ID_W-1:0]            mem_req_id_o,
  output logic [31:0]                mem_req_addr_o,
  output logic                       mem_req_we_o,
  output logic [31:0]                mem_req_wdata_o,
  input  logic                       mem_resp_valid_i,
  input  logic [31:0]                mem_resp_rdata_i,
  input  logic                       mem_resp_err_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [ID_W-1:0]            wb_id_o,
  output logic [2:0]                 wb_instr_o,
  output logic [4:0]                 wb_rd_o,
  output logic [4:0]                 wb_rs1_o,
  output logic [ACC_W-1:0]           wb_result_o,
  output logic [31:0]                wb_rdata_o,
  output logic                       wb_err_o,
  output logic                       wb_sat_o
);

  localparam int unsigned SH_W   = $clog2(ACC_W);
  localparam int unsigned PROD_W = 2 * LANE_W;
  localparam int unsigned SUM_W  = ACC_W + 2 * LANE_W + $clog2(NLANES) + 1;

  localparam logic [2:0] I_LW    = 3'd1;
  localparam logic [2:0] I_SW    = 3'd2;
  localparam logic [2:0] I_DOTP  = 3'd3;
  localparam logic [2:0] I_DOTPS = 3'd4;

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(ACC_MAX);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic [31:0]       req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [31:0]       req_wdata_q, req_wdata_d;
  logic [2:0]        pend_instr_q, pend_instr_d;
  logic [4:0]        pend_rd_q, pend_rd_d;
  logic [4:0]        pend_rs1_q, pend_rs1_d;
  logic [31:0]       pend_next_q, pend_next_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ID_W-1:0]   wb_id_q, wb_id_d;
  logic [2:0]        wb_instr_q, wb_instr_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [4:0]        wb_rs1_q, wb_rs1_d;
  logic [ACC_W-1:0]  wb_result_q, wb_result_d;
  logic [31:0]       wb_rdata_q, wb_rdata_d;
  logic              wb_err_q, wb_err_d;
  logic              wb_sat_q, wb_sat_d;

  logic signed [LANE_W-1:0] lane_a, lane_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_c;
  logic signed [SUM_W-1:0]  sum_wide, rnd, sum_rnd, sum_sh;
  logic [ACC_W-1:0]         dotp_res, dotps_res;
  logic                     dotps_sat;
  logic [31:0]              addr, addr_next;
  logic                     misaligned, issue, kill_req;

  assign acc_c = op_c_i;

  // Full-precision dot product; the wrapped result is simply its low bits.
  always_comb begin
    lane_a   = '0;
    lane_b   = '0;
    prod     = '0;
    sum_wide = SUM_W'(acc_c);
    for (int unsigned i = 0; i < NLANES; i++) begin
      lane_a   = op_a_i[i*LANE_W +: LANE_W];
      lane_b   = op_b_i[i*LANE_W +: LANE_W];
      prod     = PROD_W'(lane_a) * PROD_W'(lane_b);
      sum_wide = sum_wide + SUM_W'(prod);
    end
    rnd       = (shift_i != '0) ? (SUM_W'(1) << (shift_i - SH_W'(1))) : '0;
    sum_rnd   = sum_wide + rnd;
    sum_sh    = sum_rnd >>> shift_i;
    dotp_res  = sum_wide[ACC_W-1:0];
    dotps_sat = 1'b0;
    dotps_res = sum_sh[ACC_W-1:0];
    if (sum_sh > SAT_MAX) begin
      dotps_res = ACC_MAX;
      dotps_sat = 1'b1;
    end else if (sum_sh < SAT_MIN) begin
      dotps_res = ACC_MIN;
      dotps_sat = 1'b1;
    end
  end

  assign addr       = id_base_i + {{20{id_offset_i[11]}}, id_offset_i};
  assign addr_next  = addr + 32'd4;
  assign misaligned = (addr[1:0] != 2'b00);

  assign id_ready_o = (state_q == S_IDLE) && (!wb_valid_q || wb_ready_i);
  assign issue      = id_valid_i && id_ready_o;
  assign kill_req   = kill_i && (kill_id_i == req_id_q);

  // Next-state, request capture and write-back register loading.
  always_comb begin
    state_d      = state_q;
    req_id_d     = req_id_q;
    req_addr_d   = req_addr_q;
    req_we_d     = req_we_q;
    req_wdata_d  = req_wdata_q;
    pend_instr_d = pend_instr_q;
    pend_rd_d    = pend_rd_q;
    pend_rs1_d   = pend_rs1_q;
    pend_next_d  = pend_next_q;
    wb_valid_d   = wb_valid_q;
    wb_id_d      = wb_id_q;
    wb_instr_d   = wb_instr_q;
    wb_rd_d      = wb_rd_q;
    wb_rs1_d     = wb_rs1_q;
    wb_result_d  = wb_result_q;
    wb_rdata_d   = wb_rdata_q;
    wb_err_d     = wb_err_q;
    wb_sat_d     = wb_sat_q;

    if (wb_valid_q && wb_ready_i) wb_valid_d = 1'b0;
    if (wb_valid_q && kill_i && (kill_id_i == wb_id_q)) wb_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (issue) begin
          wb_id_d    = id_id_i;
          wb_instr_d = id_instr_i;
          wb_rd_d    = id_rd_i;
          wb_rs1_d   = id_rs1_i;
          wb_rdata_d = '0;
          wb_err_d   = 1'b0;
          wb_sat_d   = 1'b0;
          if (id_instr_i == I_DOTP) begin
            wb_valid_d  = 1'b1;
            wb_result_d = dotp_res;
          end else if (id_instr_i == I_DOTPS) begin
            wb_valid_d  = 1'b1;
            wb_result_d = dotps_res;
            wb_sat_d    = dotps_sat;
          end else if ((id_instr_i == I_LW) || (id_instr_i == I_SW)) begin
            if (misaligned) begin
              wb_valid_d  = 1'b1;
              wb_result_d = ACC_W'(id_base_i);
              wb_err_d    = 1'b1;
            end else begin
              state_d      = S_REQ;
              req_id_d     = id_id_i;
              req_addr_d   = addr;
              req_we_d     = (id_instr_i == I_SW);
              req_wdata_d  = sdata_i;
              pend_instr_d = id_instr_i;
              pend_rd_d    = id_rd_i;
              pend_rs1_d   = id_rs1_i;
              pend_next_d  = addr_next;
            end
          end
        end
      end
      S_REQ: begin
        // A kill racing the handshake still leaves a response to absorb.
        if (kill_req) state_d = mem_req_ready_i ? S_DRAIN : S_IDLE;
        else if (mem_req_ready_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid_i) begin
          state_d = S_IDLE;
          if (!kill_req) begin
            wb_valid_d  = 1'b1;
            wb_id_d     = req_id_q;
            wb_instr_d  = pend_instr_q;
            wb_rd_d     = pend_rd_q;
            wb_rs1_d    = pend_rs1_q;
            wb_result_d = ACC_W'(pend_next_q);
            wb_rdata_d  = req_we_q ? 32'd0 : mem_resp_rdata_i;
            wb_err_d    = mem_resp_err_i;
            wb_sat_d    = 1'b0;
          end
        end else if (kill_req) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      req_id_q     <= '0;
      req_addr_q   <= '0;
      req_we_q     <= 1'b0;
      req_wdata_q  <= '0;
      pend_instr_q <= '0;
      pend_rd_q    <= '0;
      pend_rs1_q   <= '0;
      pend_next_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_id_q      <= '0;
      wb_instr_q   <= '0;
      wb_rd_q      <= '0;
      wb_rs1_q     <= '0;
      wb_result_q  <= '0;
      wb_rdata_q   <= '0;
      wb_err_q     <= 1'b0;
      wb_sat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_id_q     <= req_id_d;
      req_addr_q   <= req_addr_d;
      req_we_q     <= req_we_d;
      req_wdata_q  <= req_wdata_d;
      pend_instr_q <= pend_instr_d;
      pend_rd_q    <= pend_rd_d;
      pend_rs1_q   <= pend_rs1_d;
      pend_next_q  <= pend_next_d;
      wb_valid_q   <= wb_valid_d;
      wb_id_q      <= wb_id_d;
      wb_instr_q   <= wb_instr_d;
      wb_rd_q      <= wb_rd_d;
      wb_rs1_q     <= wb_rs1_d;
      wb_result_q  <= wb_result_d;
      wb_rdata_q   <= wb_rdata_d;
      wb_err_q     <= wb_err_d;
      wb_sat_q     <= wb_sat_d;
    end
  end

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_id_o    = req_id_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_we_o    = req_we_q;
  assign mem_req_wdata_o = req_wdata_q;

  assign wb_valid_o  = wb_valid_q;
  assign wb_id_o     = wb_id_q;
  assign wb_instr_o  = wb_instr_q;
  assign wb_rd_o     = wb_rd_q;
  assign wb_rs1_o    = wb_rs1_q;
  assign wb_result_o = wb_result_q;
  assign wb_rdata_o  = wb_rdata_q;
  assign wb_err_o    = wb_err_q;
  assign wb_sat_o    = wb_sat_q;

endmodule

// File: tb/tb_fir_xifu_simd_ex.sv
// Bench for fir_xifu_simd_ex: scenario tasks plus a write-back scoreboard fed
// with expected entries at issue time.
module tb_fir_xifu_simd_ex;

  logic        clk_i, rst_ni;
  logic        id_valid_i, id_ready_o;
  logic [2:0]  id_instr_i;
  logic [3:0]  id_id_i;
  logic [4:0]  id_rd_i, id_rs1_i;
  logic [31:0] id_base_i;
  logic [11:0] id_offset_i;
  logic [31:0] op_a_i, op_b_i, op_c_i;
  logic [4:0]  shift_i;
  logic [31:0] sdata_i;
  logic        kill_i;
  logic [3:0]  kill_id_i;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [3:0]  mem_req_id_o;
  logic [31:0] mem_req_addr_o;
  logic        mem_req_we_o;
  logic [31:0] mem_req_wdata_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_rdata_i;
  logic        mem_resp_err_i;
  logic        wb_valid_o, wb_ready_i;
  logic [3:0]  wb_id_o;
  logic [2:0]  wb_instr_o;
  logic [4:0]  wb_rd_o, wb_rs1_o;
  logic [31:0] wb_result_o, wb_rdata_o;
  logic        wb_err_o, wb_sat_o;

  typedef struct packed {
    logic [3:0]  id;
    logic [2:0]  instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] result;
    logic [31:0] rdata;
    logic        err;
    logic        sat;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  fir_xifu_simd_ex dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_instr_i(id_instr_i),
    .id_id_i(id_id_i), .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i),
    .id_base_i(id_base_i), .id_offset_i(id_offset_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .op_c_i(op_c_i), .shift_i(shift_i),
    .sdata_i(sdata_i), .kill_i(kill_i), .kill_id_i(kill_id_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_id_o(mem_req_id_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_we_o(mem_req_we_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .mem_resp_err_i(mem_resp_err_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_id_o(wb_id_o),
    .wb_instr_o(wb_instr_o), .wb_rd_o(wb_rd_o), .wb_rs1_o(wb_rs1_o),
    .wb_result_o(wb_result_o), .wb_rdata_o(wb_rdata_o),
    .wb_err_o(wb_err_o), .wb_sat_o(wb_sat_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Reference dot product in 64-bit signed arithmetic (2 lanes of 16 bits).
  function automatic exp_t model_dot(input logic [2:0] instr, input logic [3:0] id,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] c, input logic [4:0] sh);
    exp_t   e;
    longint s, r;
    e = '0;
    e.id = id; e.instr = instr; e.rd = rd; e.rs1 = rs1;
    s = longint'(signed'(c));
    s = s + longint'(signed'(a[15:0])) * longint'(signed'(b[15:0]));
    s = s + longint'(signed'(a[31:16])) * longint'(signed'(b[31:16]));
    if (instr == 3'd3) begin
      e.result = s[31:0];
    end else begin
      r = s;
      if (sh != 5'd0) r = r + (longint'(1) << (sh - 5'd1));
      r = r >>> sh;
      if (r > 64'sh7FFFFFFF) begin
        e.result = 32'h7FFFFFFF; e.sat = 1'b1;
      end else if (r < -64'sh80000000) begin
        e.result = 32'h80000000; e.sat = 1'b1;
      end else begin
        e.result = r[31:0];
      end
    end
    return e;
  endfunction

  // Offer one instruction and hold it until accepted (bounded).
  task automatic issue(input logic [2:0] instr, input logic [3:0] id,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [31:0] base, input logic [11:0] off,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                       input logic [4:0] sh, input logic [31:0] sd, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    id_valid_i = 1'b1; id_instr_i = instr; id_id_i = id; id_rd_i = rd; id_rs1_i = rs1;
    id_base_i = base; id_offset_i = off; op_a_i = a; op_b_i = b; op_c_i = c;
    shift_i = sh; sdata_i = sd;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk_i);
      if (id_ready_o) acc = 1'b1;
      else waited++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout id=%0d never accepted", id);
      id_valid_i = 1'b0;
    end else begin
      @(posedge clk_i);
      #1;
      id_valid_i = 1'b0;
    end
  endtask

  // Scoreboard: every write-back handshake must match the oldest expectation.
  initial begin
    exp_t got, exp;
    forever begin
      @(negedge clk_i);
      if (rst_ni && wb_valid_o && wb_ready_i) begin
        got = {wb_id_o, wb_instr_o, wb_rd_o, wb_rs1_o, wb_result_o, wb_rdata_o, wb_err_o, wb_sat_o};
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected got=%h required=none", got);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL wb_entry got=%h required=%h", got, exp);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_ni = 1'b0;
    id_valid_i = 0; id_instr_i = 0; id_id_i = 0; id_rd_i = 0; id_rs1_i = 0;
    id_base_i = 0; id_offset_i = 0; op_a_i = 0; op_b_i = 0; op_c_i = 0;
    shift_i = 0; sdata_i = 0; kill_i = 0; kill_id_i = 0; mem_req_ready_i = 0;
    mem_resp_valid_i = 0; mem_resp_rdata_i = 0; mem_resp_err_i = 0; wb_ready_i = 1;
    #12;
    checks++;
    if ({mem_req_valid_o, mem_req_id_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o} !== 70'd0) begin
      errors++; $display("FAIL reset_mem got=%h required=0", mem_req_addr_o);
    end
    checks++;
    if ({wb_valid_o, wb_id_o, wb_instr_o, wb_rd_o, wb_rs1_o, wb_result_o, wb_rdata_o,
         wb_err_o, wb_sat_o} !== 84'd0) begin
      errors++; $display("FAIL reset_wb got valid=%b result=%h required=0", wb_valid_o, wb_result_o);
    end
    checks++;
    if (id_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_id_ready got=%b required=1", id_ready_o);
    end
    rst_ni = 1'b1;
    cyc();
  endtask

  task automatic test_dotp();
    int w;
    sb_q.push_back(model_dot(3'd3, 4'd1, 5'd5, 5'd6, {16'hFFFE, 16'd3}, {16'd5, 16'd4}, 32'd100, 5'd0));
    issue(3'd3, 4'd1, 5'd5, 5'd6, 32'd0, 12'd0, {16'hFFFE, 16'd3}, {16'd5, 16'd4}, 32'd100, 5'd0, 32'd0, w);
    checks++;
    if (wb_valid_o !== 1'b1 || wb_result_o !== 32'd102 || wb_sat_o !== 1'b0) begin
      errors++; $display("FAIL dotp_basic got v=%b r=%0d s=%b required v=1 r=102 s=0", wb_valid_o, wb_result_o, wb_sat_o);
    end
    cyc();
  endtask

  task automatic test_dotps();
    int w;
    sb_q.push_back(model_dot(3'd4, 4'd2, 5'd7, 5'd8, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFFFFFF, 5'd0));
    issue(3'd4, 4'd2, 5'd7, 5'd8, 32'd0, 12'd0, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFFFFFF, 5'd0, 32'd0, w);
    checks++;
    if (wb_result_o !== 32'h7FFFFFFF || wb_sat_o !== 1'b1) begin
      errors++; $display("FAIL dotps_sat got r=%h s=%b required r=7fffffff s=1", wb_result_o, wb_sat_o);
    end
    sb_q.push_back(model_dot(3'd4, 4'd3, 5'd7, 5'd8, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFFFFFF, 5'd16));
    issue(3'd4, 4'd3, 5'd7, 5'd8, 32'd0, 12'd0, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFFFFFF, 5'd16, 32'd0, w);
    checks++;
    if (wb_sat_o !== 1'b0) begin
      errors++; $display("FAIL dotps_shift_sat got=%b required=0", wb_sat_o);
    end
    sb_q.push_back(model_dot(3'd4, 4'd4, 5'd1, 5'd2, 32'h80008000, 32'h7FFF7FFF, 32'h80000000, 5'd1));
    issue(3'd4, 4'd4, 5'd1, 5'd2, 32'd0, 12'd0, 32'h80008000, 32'h7FFF7FFF, 32'h80000000, 5'd1, 32'd0, w);
    cyc();
  endtask

  task automatic test_lw();
    int w;
    sb_q.push_back('{id: 4'd3, instr: 3'd1, rd: 5'd9, rs1: 5'd10, result: 32'h1000,
                     rdata: 32'hCAFEBABE, err: 1'b0, sat: 1'b0});
    issue(3'd1, 4'd3, 5'd9, 5'd10, 32'h1000, 12'hFFC, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, w);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'hFFC || mem_req_we_o !== 1'b0 ||
          mem_req_id_o !== 4'd3 || id_ready_o !== 1'b0) begin
        errors++; $display("FAIL lw_req cyc=%0d got v=%b a=%h we=%b rdy=%b required v=1 a=ffc we=0 rdy=0",
                           i, mem_req_valid_o, mem_req_addr_o, mem_req_we_o, id_ready_o);
      end
      if (i == 2) mem_req_ready_i = 1'b1;
      cyc();
    end
    mem_req_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_req_valid_o !== 1'b0 || id_ready_o !== 1'b0 || wb_valid_o !== 1'b0) begin
        errors++; $display("FAIL lw_wait cyc=%0d got v=%b rdy=%b wbv=%b required 0 0 0",
                           i, mem_req_valid_o, id_ready_o, wb_valid_o);
      end
      if (i == 2) begin mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'hCAFEBABE; end
      cyc();
    end
    mem_resp_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b1 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL lw_done got wbv=%b rdy=%b required 1 1", wb_valid_o, id_ready_o);
    end
    cyc();
  endtask

  task automatic test_store();
    int w;
    sb_q.push_back('{id: 4'd6, instr: 3'd2, rd: 5'd0, rs1: 5'd3, result: 32'h200C,
                     rdata: 32'd0, err: 1'b1, sat: 1'b0});
    issue(3'd2, 4'd6, 5'd0, 5'd3, 32'h2000, 12'd8, 32'd0, 32'd0, 32'd0, 5'd0, 32'h12345678, w);
    checks++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h2008 || mem_req_we_o !== 1'b1 ||
        mem_req_wdata_o !== 32'h12345678) begin
      errors++; $display("FAIL sw_req got v=%b a=%h we=%b d=%h required 1 2008 1 12345678",
                         mem_req_valid_o, mem_req_addr_o, mem_req_we_o, mem_req_wdata_o);
    end
    mem_req_ready_i = 1'b1; cyc(); mem_req_ready_i = 1'b0;
    mem_resp_valid_i = 1'b1; mem_resp_err_i = 1'b1; mem_resp_rdata_i = 32'hDEADBEEF;
    cyc();
    mem_resp_valid_i = 1'b0; mem_resp_err_i = 1'b0;
    // Misaligned store: no memory traffic, error write-back carrying the base.
    sb_q.push_back('{id: 4'd7, instr: 3'd2, rd: 5'd0, rs1: 5'd4, result: 32'h1002,
                     rdata: 32'd0, err: 1'b1, sat: 1'b0});
    issue(3'd2, 4'd7, 5'd0, 5'd4, 32'h1002, 12'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'hFFFF, w);
    checks++;
    if (mem_req_valid_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_err_o !== 1'b1) begin
      errors++; $display("FAIL sw_misaligned got v=%b wbv=%b err=%b required 0 1 1",
                         mem_req_valid_o, wb_valid_o, wb_err_o);
    end
    cyc();
  endtask

  task automatic test_kill();
    int w;
    // Kill in WAIT: response discarded.
    issue(3'd1, 4'd3, 5'd1, 5'd1, 32'h100, 12'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, w);
    mem_req_ready_i = 1'b1; cyc(); mem_req_ready_i = 1'b0;
    kill_i = 1'b1; kill_id_i = 4'd3; cyc(); kill_i = 1'b0;
    checks++;
    if (id_ready_o !== 1'b0) begin
      errors++; $display("FAIL kill_wait_drain got rdy=%b required 0", id_ready_o);
    end
    mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'h55AA55AA; cyc(); mem_resp_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL kill_wait_done got wbv=%b rdy=%b required 0 1", wb_valid_o, id_ready_o);
    end
    sb_q.push_back(model_dot(3'd3, 4'd8, 5'd2, 5'd3, 32'h00050007, 32'hFFFF0002, 32'd9, 5'd0));
    issue(3'd3, 4'd8, 5'd2, 5'd3, 32'd0, 12'd0, 32'h00050007, 32'hFFFF0002, 32'd9, 5'd0, 32'd0, w);
    cyc();
    // Non-matching kill leaves a pending entry; matching kill clears it.
    wb_ready_i = 1'b0;
    sb_q.push_back(model_dot(3'd3, 4'd3, 5'd4, 5'd5, 32'h00010001, 32'h00010001, 32'd0, 5'd0));
    issue(3'd3, 4'd3, 5'd4, 5'd5, 32'd0, 12'd0, 32'h00010001, 32'h00010001, 32'd0, 5'd0, 32'd0, w);
    kill_i = 1'b1; kill_id_i = 4'd5; cyc(); kill_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b1 || wb_id_o !== 4'd3) begin
      errors++; $display("FAIL kill_nomatch got wbv=%b id=%0d required 1 3", wb_valid_o, wb_id_o);
    end
    wb_ready_i = 1'b1; cyc(); wb_ready_i = 1'b0;
    issue(3'd3, 4'd4, 5'd4, 5'd5, 32'd0, 12'd0, 32'h00020002, 32'h00020002, 32'd0, 5'd0, 32'd0, w);
    kill_i = 1'b1; kill_id_i = 4'd4; cyc(); kill_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL kill_wb got wbv=%b required 0", wb_valid_o);
    end
    wb_ready_i = 1'b1;
    // Kill in REQ without handshake: request dropped.
    issue(3'd1, 4'd6, 5'd1, 5'd1, 32'h200, 12'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, w);
    kill_i = 1'b1; kill_id_i = 4'd6; cyc(); kill_i = 1'b0;
    checks++;
    if (mem_req_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL kill_req got v=%b rdy=%b required 0 1", mem_req_valid_o, id_ready_o);
    end
    // Kill in REQ together with the handshake: response still drained.
    issue(3'd1, 4'd7, 5'd1, 5'd1, 32'h300, 12'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, w);
    kill_i = 1'b1; kill_id_i = 4'd7; mem_req_ready_i = 1'b1; cyc();
    kill_i = 1'b0; mem_req_ready_i = 1'b0;
    checks++;
    if (mem_req_valid_o !== 1'b0 || id_ready_o !== 1'b0) begin
      errors++; $display("FAIL kill_req_rdy got v=%b rdy=%b required 0 0", mem_req_valid_o, id_ready_o);
    end
    mem_resp_valid_i = 1'b1; cyc(); mem_resp_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL kill_req_drain got wbv=%b rdy=%b required 0 1", wb_valid_o, id_ready_o);
    end
  endtask

  task automatic test_backpressure();
    int   w;
    exp_t e0, e1;
    wb_ready_i = 1'b0;
    e0 = model_dot(3'd3, 4'd9, 5'd11, 5'd12, 32'h01230456, 32'hFF00F0F0, 32'h00001000, 5'd0);
    sb_q.push_back(e0);
    issue(3'd3, 4'd9, 5'd11, 5'd12, 32'd0, 12'd0, 32'h01230456, 32'hFF00F0F0, 32'h00001000, 5'd0, 32'd0, w);
    e1 = model_dot(3'd4, 4'd10, 5'd13, 5'd14, 32'h7FFF8000, 32'h80008000, 32'h7FFFFFFF, 5'd3);
    sb_q.push_back(e1);
    id_valid_i = 1'b1; id_instr_i = 3'd4; id_id_i = 4'd10; id_rd_i = 5'd13; id_rs1_i = 5'd14;
    op_a_i = 32'h7FFF8000; op_b_i = 32'h80008000; op_c_i = 32'h7FFFFFFF; shift_i = 5'd3;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wb_valid_o !== 1'b1 || wb_result_o !== e0.result || wb_id_o !== 4'd9 || id_ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got v=%b r=%h id=%0d rdy=%b required 1 %h 9 0",
                           i, wb_valid_o, wb_result_o, wb_id_o, id_ready_o, e0.result);
      end
      cyc();
    end
    wb_ready_i = 1'b1;
    cyc();
    id_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b1 || wb_id_o !== 4'd10) begin
      errors++; $display("FAIL bp_resume got v=%b id=%0d required 1 10", wb_valid_o, wb_id_o);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int          w;
    logic [2:0]  ins;
    logic [31:0] a, b, c;
    logic [4:0]  sh;
    for (int i = 0; i < 10; i++) begin
      ins = (($urandom_range(0, 1)) != 0) ? 3'd4 : 3'd3;
      a = $urandom(); b = $urandom(); c = $urandom(); sh = 5'($urandom_range(0, 31));
      sb_q.push_back(model_dot(ins, 4'(i), 5'(i), 5'(i + 1), a, b, c, sh));
      issue(ins, 4'(i), 5'(i), 5'(i + 1), 32'd0, 12'd0, a, b, c, sh, 32'd0, w);
      checks++;
      if (w != 0) begin
        errors++; $display("FAIL b2b_stall op=%0d got wait=%0d required 0", i, w);
      end
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int w;
    issue(3'd1, 4'd2, 5'd1, 5'd1, 32'h400, 12'd0, 32'd0, 32'd0, 32'd0, 5'd0, 32'd0, w);
    mem_req_ready_i = 1'b1; cyc(); mem_req_ready_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    checks++;
    if (mem_req_valid_o !== 1'b0 || id_ready_o !== 1'b1 || wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid got v=%b rdy=%b wbv=%b required 0 1 0", mem_req_valid_o, id_ready_o, wb_valid_o);
    end
    cyc();
    rst_ni = 1'b1;
    cyc();
    mem_resp_valid_i = 1'b1; mem_resp_rdata_i = 32'h0BADF00D; cyc(); mem_resp_valid_i = 1'b0;
    checks++;
    if (wb_valid_o !== 1'b0 || id_ready_o !== 1'b1) begin
      errors++; $display("FAIL rst_stale_resp got wbv=%b rdy=%b required 0 1", wb_valid_o, id_ready_o);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_dotp();
    test_dotps();
    test_lw();
    test_store();
    test_kill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    cyc(); cyc();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain got pending=%0d required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
